// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing one single-ported data-memory bus between the core data port
// and the I-cache refill engine. Define DMEM_ARB_DATA_PRIORITY_EN for fixed data priority.
module dmem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  input  logic [3:0]        d_req_be,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              d_stall,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_rdata,
  output logic              i_rsp_last,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_be,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_WAIT  = 3'd2,
    I_ISSUE = 3'd3,
    I_WAIT  = 3'd4
  } state_t;

  state_t            state_r;
  logic [BEAT_W-1:0] beat_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [31:0]       wdata_r;
  logic [3:0]        be_r;
  logic              store_done_r;
  logic              grant_d_s;
  logic              grant_i_s;

`ifdef DMEM_ARB_DATA_PRIORITY_EN
  // Grant selection: data always wins, refill only when data is absent
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      grant_d_s = d_req_valid;
      grant_i_s = i_req_valid & ~d_req_valid;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end
`else
  logic rr_last_instr_r;

  // Grant selection: round-robin on contention, immediate grant otherwise
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req_valid && i_req_valid) begin
        grant_d_s = rr_last_instr_r;
        grant_i_s = ~rr_last_instr_r;
      end else begin
        grant_d_s = d_req_valid;
        grant_i_s = i_req_valid;
      end
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Round-robin history; reset to INSTR so the first contention goes to data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_instr_r <= 1'b1;
    end else if (grant_d_s) begin
      rr_last_instr_r <= 1'b0;
    end else if (grant_i_s) begin
      rr_last_instr_r <= 1'b1;
    end else begin
      rr_last_instr_r <= rr_last_instr_r;
    end
  end
`endif

  // Transaction sequencer: capture the winner, issue beats, track the burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      beat_r       <= '0;
      addr_r       <= '0;
      we_r         <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      be_r         <= 4'b0000;
      store_done_r <= 1'b0;
    end else begin
      store_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            addr_r  <= d_req_addr;
            we_r    <= d_req_we;
            wdata_r <= d_req_we ? d_req_wdata : 32'h0000_0000;
            be_r    <= d_req_we ? d_req_be : 4'b0000;
            state_r <= D_ISSUE;
          end else if (grant_i_s) begin
            addr_r  <= i_req_addr;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
            beat_r  <= '0;
            state_r <= I_ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        D_ISSUE: begin
          if (mem_req_ready) begin
            // Stores get no memory response, so complete them locally
            if (we_r) begin
              store_done_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              state_r <= D_WAIT;
            end
          end else begin
            state_r <= D_ISSUE;
          end
        end
        D_WAIT: begin
          if (mem_rsp_valid) begin
            state_r <= IDLE;
          end else begin
            state_r <= D_WAIT;
          end
        end
        I_ISSUE: begin
          if (mem_req_ready) begin
            state_r <= I_WAIT;
          end else begin
            state_r <= I_ISSUE;
          end
        end
        I_WAIT: begin
          if (mem_rsp_valid) begin
            if (beat_r == LAST_BEAT) begin
              beat_r  <= '0;
              state_r <= IDLE;
            end else begin
              beat_r  <= beat_r + 1'b1;
              state_r <= I_ISSUE;
            end
          end else begin
            state_r <= I_WAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Port outputs decoded from state and the captured request fields
  always_comb begin
    d_req_ready   = grant_d_s;
    i_req_ready   = grant_i_s;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = 32'h0000_0000;
    mem_req_be    = 4'b0000;
    d_rsp_valid   = store_done_r;
    d_rsp_rdata   = 32'h0000_0000;
    i_rsp_valid   = 1'b0;
    i_rsp_rdata   = 32'h0000_0000;
    i_rsp_last    = 1'b0;
    d_stall       = d_req_valid | store_done_r;
    case (state_r)
      D_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_r;
        mem_req_addr  = addr_r;
        mem_req_wdata = wdata_r;
        mem_req_be    = be_r;
        d_stall       = 1'b1;
      end
      D_WAIT: begin
        d_stall = 1'b1;
        if (mem_rsp_valid) begin
          d_rsp_valid = 1'b1;
          d_rsp_rdata = mem_rsp_rdata;
        end else begin
          d_rsp_valid = 1'b0;
        end
      end
      I_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_r[ADDR_W-1:BEAT_W+2], beat_r, 2'b00};
      end
      I_WAIT: begin
        if (mem_rsp_valid) begin
          i_rsp_valid = 1'b1;
          i_rsp_rdata = mem_rsp_rdata;
          i_rsp_last  = (beat_r == LAST_BEAT);
        end else begin
          i_rsp_valid = 1'b0;
        end
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (default round-robin build).
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_req_valid = 1'b0, d_req_we = 1'b0;
  logic [31:0] d_req_addr = 32'h0, d_req_wdata = 32'h0;
  logic [3:0]  d_req_be = 4'h0;
  logic        d_req_ready, d_rsp_valid, d_stall;
  logic [31:0] d_rsp_rdata;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic        i_req_ready, i_rsp_valid, i_rsp_last;
  logic [31:0] i_rsp_rdata;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  logic [31:0] obs_addr [4];
  logic        obs_iv [4];
  logic        obs_last [4];
  logic [31:0] obs_data [4];
  logic        obs_dready_any, obs_stall_drop, obs_both_rsp;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.BURST_LEN(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_stall(d_stall),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_last(i_rsp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    d_req_valid = 1'b0; d_req_we = 1'b0; i_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Memory responder for one refill burst; starts in the first I_ISSUE cycle,
  // optionally raises a data load at the given beat, and records observations.
  task automatic serve_burst(input int raise_d_beat);
    obs_dready_any = 1'b0; obs_stall_drop = 1'b0; obs_both_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == raise_d_beat) begin
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0000_0300;
      end
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      @(negedge clk);
      obs_addr[k] = mem_req_valid ? mem_req_addr : 32'hFFFF_FFFF;
      obs_dready_any |= d_req_ready;
      obs_stall_drop |= d_req_valid & ~d_stall;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hA000_0000 + k;
      @(negedge clk);
      obs_iv[k] = i_rsp_valid; obs_last[k] = i_rsp_last; obs_data[k] = i_rsp_rdata;
      obs_dready_any |= d_req_ready;
      obs_stall_drop |= d_req_valid & ~d_stall;
      obs_both_rsp |= d_rsp_valid & i_rsp_valid;
      step();
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    total++; if ({d_req_ready, i_req_ready, d_rsp_valid, i_rsp_valid, i_rsp_last, d_stall} !== 6'b0) begin bad++; $display("FAIL reset_ctrl_outs got=%b exp=000000", {d_req_ready, i_req_ready, d_rsp_valid, i_rsp_valid, i_rsp_last, d_stall}); end
    total++; if ({mem_req_addr, mem_req_wdata, mem_req_be, mem_req_we} !== 69'h0) begin bad++; $display("FAIL reset_mem_fields got=%h exp=0", {mem_req_addr, mem_req_wdata, mem_req_be, mem_req_we}); end
    apply_reset();
  endtask

  task automatic test_single_load();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0000_0100; d_req_be = 4'hF;
    @(negedge clk);
    total++; if ({d_req_ready, d_stall, mem_req_valid} !== 3'b110) begin bad++; $display("FAIL load_c0 ready/stall/memv got=%b exp=110", {d_req_ready, d_stall, mem_req_valid}); end
    step(); d_req_valid = 1'b0;
    @(negedge clk);
    total++; if ({mem_req_valid, mem_req_we, mem_req_be, d_stall, d_req_ready} !== 8'b1_0_0000_1_0) begin bad++; $display("FAIL load_c1 v/we/be/stall/rdy got=%b exp=10000010", {mem_req_valid, mem_req_we, mem_req_be, d_stall, d_req_ready}); end
    total++; if (mem_req_addr !== 32'h0000_0100) begin bad++; $display("FAIL load_addr got=%h exp=00000100", mem_req_addr); end
    step(); mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if ({mem_req_valid, d_rsp_valid, d_stall} !== 3'b101) begin bad++; $display("FAIL load_c2 got=%b exp=101", {mem_req_valid, d_rsp_valid, d_stall}); end
    step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if ({d_rsp_valid, d_stall, mem_req_valid, i_rsp_valid} !== 4'b1100) begin bad++; $display("FAIL load_c3 rspv/stall/memv/irsp got=%b exp=1100", {d_rsp_valid, d_stall, mem_req_valid, i_rsp_valid}); end
    total++; if (d_rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", d_rsp_rdata); end
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if ({d_rsp_valid, d_stall} !== 2'b00) begin bad++; $display("FAIL load_c4 got=%b exp=00", {d_rsp_valid, d_stall}); end
    step();
  endtask

  task automatic test_store_stall();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h0000_0204;
    d_req_wdata = 32'h0000_ABCD; d_req_be = 4'b0011;
    @(negedge clk);
    total++; if (d_req_ready !== 1'b1) begin bad++; $display("FAIL store_accept got=%b exp=1", d_req_ready); end
    step(); d_req_valid = 1'b0; d_req_wdata = 32'h1111_1111; d_req_be = 4'hF; d_req_addr = 32'h0;
    for (int c = 0; c < 4; c++) begin
      mem_req_ready = (c == 3);
      @(negedge clk);
      total++; if ({mem_req_valid, mem_req_we, mem_req_be, d_rsp_valid, d_stall} !== 8'b1_1_0011_0_1) begin bad++; $display("FAIL store_hold%0d v/we/be/rsp/stall got=%b exp=11001101", c, {mem_req_valid, mem_req_we, mem_req_be, d_rsp_valid, d_stall}); end
      total++; if ({mem_req_addr, mem_req_wdata} !== {32'h0000_0204, 32'h0000_ABCD}) begin bad++; $display("FAIL store_hold%0d addr/wdata got=%h exp=000002040000abcd", c, {mem_req_addr, mem_req_wdata}); end
      step();
    end
    mem_req_ready = 1'b0;
    @(negedge clk);
    total++; if ({d_rsp_valid, d_stall, mem_req_valid, d_rsp_rdata} !== {3'b110, 32'h0}) begin bad++; $display("FAIL store_rsp rspv/stall/memv/rdata got=%h exp=%h", {d_rsp_valid, d_stall, mem_req_valid, d_rsp_rdata}, {3'b110, 32'h0}); end
    step();
    @(negedge clk);
    total++; if ({d_rsp_valid, d_stall} !== 2'b00) begin bad++; $display("FAIL store_after got=%b exp=00", {d_rsp_valid, d_stall}); end
    step();
  endtask

  task automatic test_refill();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1034;
    @(negedge clk);
    total++; if ({i_req_ready, mem_req_valid} !== 2'b10) begin bad++; $display("FAIL refill_accept got=%b exp=10", {i_req_ready, mem_req_valid}); end
    step(); i_req_valid = 1'b0;
    serve_burst(-1);
    for (int k = 0; k < 4; k++) begin
      total++; if (obs_addr[k] !== 32'h0000_1030 + 32'(4 * k)) begin bad++; $display("FAIL refill_addr%0d got=%h exp=%h", k, obs_addr[k], 32'h0000_1030 + 32'(4 * k)); end
      total++; if ({obs_iv[k], obs_last[k]} !== {1'b1, k == 3}) begin bad++; $display("FAIL refill_vlast%0d got=%b exp=%b", k, {obs_iv[k], obs_last[k]}, {1'b1, k == 3}); end
      total++; if (obs_data[k] !== 32'hA000_0000 + 32'(k)) begin bad++; $display("FAIL refill_data%0d got=%h exp=%h", k, obs_data[k], 32'hA000_0000 + 32'(k)); end
    end
    @(negedge clk);
    total++; if ({i_rsp_valid, mem_req_valid} !== 2'b00) begin bad++; $display("FAIL refill_end got=%b exp=00", {i_rsp_valid, mem_req_valid}); end
    step();
  endtask

  task automatic test_contention();
    apply_reset();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0000_0040;
    i_req_valid = 1'b1; i_req_addr = 32'h0000_2000;
    @(negedge clk);
    total++; if ({d_req_ready, i_req_ready} !== 2'b10) begin bad++; $display("FAIL rr_first d/i got=%b exp=10", {d_req_ready, i_req_ready}); end
    step(); d_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if ({i_req_ready, mem_req_addr} !== {1'b0, 32'h0000_0040}) begin bad++; $display("FAIL rr_data_issue got=%h exp=%h", {i_req_ready, mem_req_addr}, {1'b0, 32'h0000_0040}); end
    step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0011;
    @(negedge clk);
    total++; if ({d_rsp_valid, i_req_ready} !== 2'b10) begin bad++; $display("FAIL rr_data_rsp got=%b exp=10", {d_rsp_valid, i_req_ready}); end
    step(); mem_rsp_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0044;
    @(negedge clk);
    total++; if ({d_req_ready, i_req_ready, d_stall} !== 3'b011) begin bad++; $display("FAIL rr_second d/i/stall got=%b exp=011", {d_req_ready, i_req_ready, d_stall}); end
    step(); i_req_valid = 1'b0;
    serve_burst(-1);
    total++; if ({obs_dready_any, obs_stall_drop, obs_both_rsp} !== 3'b000) begin bad++; $display("FAIL rr_burst_lock dready/stalldrop/both got=%b exp=000", {obs_dready_any, obs_stall_drop, obs_both_rsp}); end
    total++; if (obs_addr[0] !== 32'h0000_2000) begin bad++; $display("FAIL rr_refill_base got=%h exp=00002000", obs_addr[0]); end
    @(negedge clk);
    total++; if (d_req_ready !== 1'b1) begin bad++; $display("FAIL rr_data_after_burst got=%b exp=1", d_req_ready); end
    step(); d_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (mem_req_addr !== 32'h0000_0044) begin bad++; $display("FAIL rr_data2_addr got=%h exp=00000044", mem_req_addr); end
    step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0022;
    @(negedge clk);
    total++; if ({d_rsp_valid, d_rsp_rdata} !== {1'b1, 32'h0000_0022}) begin bad++; $display("FAIL rr_data2_rsp got=%h exp=%h", {d_rsp_valid, d_rsp_rdata}, {1'b1, 32'h0000_0022}); end
    step(); mem_rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_data_mid_burst();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_4000;
    @(negedge clk);
    total++; if (i_req_ready !== 1'b1) begin bad++; $display("FAIL mid_refill_accept got=%b exp=1", i_req_ready); end
    step(); i_req_valid = 1'b0;
    serve_burst(1);
    total++; if ({obs_dready_any, obs_stall_drop, obs_last[3], obs_last[2]} !== 4'b0010) begin bad++; $display("FAIL mid_lock dready/stalldrop/last3/last2 got=%b exp=0010", {obs_dready_any, obs_stall_drop, obs_last[3], obs_last[2]}); end
    @(negedge clk);
    total++; if ({d_req_ready, d_stall, i_req_ready} !== 3'b110) begin bad++; $display("FAIL mid_grant_after_last got=%b exp=110", {d_req_ready, d_stall, i_req_ready}); end
    step(); d_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_0300}) begin bad++; $display("FAIL mid_data_issue got=%h exp=%h", {mem_req_valid, mem_req_addr}, {1'b1, 32'h0000_0300}); end
    step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0033;
    @(negedge clk);
    total++; if ({d_rsp_valid, i_rsp_valid, d_rsp_rdata} !== {2'b10, 32'h0000_0033}) begin bad++; $display("FAIL mid_data_rsp got=%h exp=%h", {d_rsp_valid, i_rsp_valid, d_rsp_rdata}, {2'b10, 32'h0000_0033}); end
    step(); mem_rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_in_iwait();
    apply_reset();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_5000;
    @(negedge clk);
    step(); i_req_valid = 1'b0; mem_req_ready = 1'b1;
    step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0055;
    #1;
    total++; if (i_rsp_valid !== 1'b1) begin bad++; $display("FAIL rstw_pre_irsp got=%b exp=1", i_rsp_valid); end
    rst_n = 1'b0;
    #1;
    total++; if ({i_rsp_valid, i_rsp_last, mem_req_valid, d_rsp_valid, i_rsp_rdata} !== {4'b0000, 32'h0}) begin bad++; $display("FAIL rstw_async_outs got=%h exp=0", {i_rsp_valid, i_rsp_last, mem_req_valid, d_rsp_valid, i_rsp_rdata}); end
    @(negedge clk); rst_n = 1'b1;
    step();
    @(negedge clk);
    total++; if ({i_rsp_valid, d_rsp_valid, mem_req_valid} !== 3'b000) begin bad++; $display("FAIL rstw_stray_rsp got=%b exp=000", {i_rsp_valid, d_rsp_valid, mem_req_valid}); end
    step(); mem_rsp_valid = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0000_0080;
    i_req_valid = 1'b1; i_req_addr = 32'h0000_6000;
    @(negedge clk);
    total++; if ({d_req_ready, i_req_ready} !== 2'b10) begin bad++; $display("FAIL rstw_fresh_rr d/i got=%b exp=10", {d_req_ready, i_req_ready}); end
    step();
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_stall();
    test_refill();
    test_contention();
    test_data_mid_burst();
    test_reset_in_iwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
